regfile_32x32: RTL
==================

Name: regfile_32x32

Overview:
- Integer register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-register-address selector (rt/rd 5-bit mux).
- Consumes that selector's 5-bit output as its write address.
- Provides two combinational read ports and one synchronous write port, with optional same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width (2**ADDR_W entries).
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; one clock; sampled on rising edge of clk.
- we  input  1  write enable.
- waddr  input  ADDR_W  write register index (from rt/rd selector).
- wdata  input  DATA_W  write data (from writeback mux).
- raddr1  input  ADDR_W  read port 1 index (rs).
- raddr2  input  ADDR_W  read port 2 index (rt).
- rdata1  output  DATA_W  read port 1 data, combinational.
- rdata2  output  DATA_W  read port 2 data, combinational.
- dbg_addr  input  ADDR_W  debug read index (only with REGFILE_DBG_EN).
- dbg_data  output  DATA_W  debug read data (only with REGFILE_DBG_EN).

Behaviour:
- Storage: 2**ADDR_W entries of DATA_W bits; entry 0 is hardwired zero and is never stored.
- Reset:
  - rst high at a rising edge clears every entry to 0.
  - rst has priority over we in the same cycle; that write is discarded.
  - While rst is high, rdata1/rdata2/dbg_data read 0 regardless of address, stored contents or bypass.
- Write:
  - At a rising edge with rst=0, we=1 and waddr!=0: entry[waddr] <= wdata.
  - The new value is visible through the array from the next cycle.
  - we=1 with waddr=0 has no effect.
  - we=0 leaves all entries unchanged.
- Read, combinational, zero-cycle latency:
  - raddrN==0 -> 0.
  - Else, if BYPASS=1 and we=1 and waddr==raddrN -> wdata. This is write-first forwarding within the cycle.
  - Else -> entry[raddrN].
- Both read ports are independent; both may address the same register and both may hit the bypass simultaneously.
- Bypass never applies to index 0.
- Bypass never applies while rst=1.
- No X propagation requirement beyond inputs: unknown addresses must not corrupt non-addressed entries.
- Rising edge with rst=0, we=0: state holds.
- Reset mid-program: contents lost, next cycle all reads 0 until rewritten.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- Defined:
  - dbg_addr/dbg_data ports exist.
  - dbg_data = entry[dbg_addr] combinationally, stored value only, never bypassed.
  - Index 0 reads 0; reads 0 during rst.
  - Used by board-level seven-segment display and testbench state dumps.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=5, DATA_W=32.
  - REG_ZERO=5'd0.
  - Named register indices used by tests (REG_RA=31, REG_SP=29).
- No sub-module: the read-port logic is a few lines, duplicated per port via a function in the module.
- Storage is an inferred array in this module.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst one cycle -> rdata1 (raddr1=5) reads 0x00000000 the following cycle.
- Write then read: we=1, waddr=8, wdata=0x12345678 at edge; next cycle raddr1=8, raddr2=8 -> both 0x12345678.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> raddr1=0 reads 0 same cycle and next cycle.
- Bypass (BYPASS=1): r3 holds 0x11; same cycle we=1, waddr=3, wdata=0x22, raddr2=3 -> rdata2=0x22 before edge. With BYPASS=0 -> rdata2=0x11 before edge, 0x22 after.
- Reset priority: rst=1 and we=1, waddr=7, wdata=0xAA in same cycle -> r7 reads 0 after rst drops; rdata ports read 0 during rst.
- Debug port (REGFILE_DBG_EN): write 0x5A5A5A5A to r31, dbg_addr=31 -> dbg_data=0x5A5A5A5A next cycle; during a concurrent write to r31 of 0x1, dbg_data still shows 0x5A5A5A5A until the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register-file geometry and the architecturally
// named register indices that tests and surrounding datapath blocks refer to.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_32x32.sv
// MIPS integer register file: two combinational read ports, one synchronous write
// port, optional write-first bypass. Define REGFILE_DBG_EN to add a debug read port.
module regfile_32x32 #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DBG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);
  import cpu_pkg::*;

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_hit;

  assign wr_hit = we && (waddr != ZERO_IDX);

  // Entry 0 is never written, so its flop holds a constant zero and is trimmed.
  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
    end else if (wr_hit) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              in_rst,
    input logic              wr_act,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if (in_rst || addr == ZERO_IDX) begin
      res = '0;
    end else if (BYPASS && wr_act && wr_addr == addr) begin
      res = wr_data;
    end
    return res;
  endfunction

  assign rdata1 = rd_port(raddr1, regs_q[raddr1], rst, wr_hit, waddr, wdata);
  assign rdata2 = rd_port(raddr2, regs_q[raddr2], rst, wr_hit, waddr, wdata);

`ifdef REGFILE_DBG_EN
  // Debug view shows committed state only, so it never forwards in-flight writes.
  assign dbg_data = (rst || dbg_addr == ZERO_IDX) ? '0 : regs_q[dbg_addr];
`endif

endmodule
